// File: rtl/bin_dec_scan.sv
// rtl/bin_dec_scan.sv - registered binary-to-one-hot decoder with self-timed scan mode
// Optional: define BIN_DEC_ACTIVE_LOW_EN to drive y active-low (one-hot-zero).

module bin_dec_scan #(
  parameter int IN_W  = 4,
  parameter int OUT_N = 12,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [IN_W-1:0]  a,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] scan_div,
  output logic [OUT_N-1:0] y,
  output logic             y_valid,
  output logic             err,
  output logic [IN_W-1:0]  scan_idx
);

  typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

  localparam logic [IN_W-1:0] LAST_CODE = IN_W'(OUT_N);

  state_t           state, state_n;
  logic [OUT_N-1:0] y_q, y_n;
  logic             y_valid_n;
  logic             err_n;
  logic [IN_W-1:0]  scan_idx_n;
  logic [DIV_W-1:0] presc, presc_n;
  logic [IN_W-1:0]  idx_inc;

  // Code k drives bit k-1; 0 and anything above OUT_N decode to all-inactive.
  function automatic logic [OUT_N-1:0] onehot(input logic [IN_W-1:0] code);
    logic [OUT_N-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_N; i++) begin
      r[i] = (code == IN_W'(i + 1));
    end
    return r;
  endfunction

  assign in_ready = (state == ST_DIRECT) && !mode;
  assign idx_inc  = (scan_idx == LAST_CODE) ? IN_W'(1) : scan_idx + IN_W'(1);

  always_comb begin
    state_n    = state;
    y_n        = y_q;
    y_valid_n  = y_valid;
    err_n      = 1'b0;
    scan_idx_n = scan_idx;
    presc_n    = presc;
    case (state)
      ST_DIRECT: begin
        if (mode) begin
          state_n    = ST_SCAN;
          presc_n    = '0;
          scan_idx_n = IN_W'(1);
          y_n        = onehot(IN_W'(1));
          y_valid_n  = 1'b1;
        end else if (in_valid) begin
          y_n       = onehot(a);
          y_valid_n = 1'b1;
          err_n     = (a > LAST_CODE);
        end
      end
      ST_SCAN: begin
        if (!mode) begin
          state_n    = ST_DIRECT;
          y_n        = '0;
          y_valid_n  = 1'b0;
          scan_idx_n = '0;
          presc_n    = '0;
        end else if (presc >= scan_div) begin
          // ">=" so a divisor shrunk below the running count still wraps next edge.
          presc_n    = '0;
          scan_idx_n = idx_inc;
          y_n        = onehot(idx_inc);
        end else begin
          presc_n = presc + DIV_W'(1);
        end
      end
      default: state_n = ST_DIRECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_DIRECT;
      y_q      <= '0;
      y_valid  <= 1'b0;
      err      <= 1'b0;
      scan_idx <= '0;
      presc    <= '0;
    end else begin
      state    <= state_n;
      y_q      <= y_n;
      y_valid  <= y_valid_n;
      err      <= err_n;
      scan_idx <= scan_idx_n;
      presc    <= presc_n;
    end
  end

`ifdef BIN_DEC_ACTIVE_LOW_EN
  assign y = ~y_q;
`else
  assign y = y_q;
`endif

endmodule

// File: tb/tb_bin_dec_scan.sv
// tb/tb_bin_dec_scan.sv - self-checking bench for bin_dec_scan (decode, scan, mode switch, async reset)

module tb_bin_dec_scan;

  typedef struct packed {
    logic [11:0] y;
    logic        v;
    logic        e;
    logic [3:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic [3:0]  a;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] scan_div;
  logic [11:0] y;
  logic        y_valid;
  logic        err;
  logic [3:0]  scan_idx;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bin_dec_scan #(.IN_W(4), .OUT_N(12), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .a(a), .in_valid(in_valid),
    .in_ready(in_ready), .scan_div(scan_div), .y(y), .y_valid(y_valid),
    .err(err), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ay(input logic [11:0] x);
`ifdef BIN_DEC_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_y"},        32'(y),        32'(ay(e.y)));
    chk({tag, "_y_valid"},  32'(y_valid),  32'(e.v));
    chk({tag, "_err"},      32'(err),      32'(e.e));
    chk({tag, "_scan_idx"}, 32'(scan_idx), 32'(e.idx));
  endtask

  // Drive one cycle's inputs, check in_ready before the edge, then the registered result after it.
  task automatic cyc(input string tag, input logic m, input logic [3:0] av, input logic vv,
                     input logic [15:0] d, input logic er, input logic [11:0] ey,
                     input logic ev, input logic ee, input logic [3:0] ei);
    exp_t e;
    mode = m; a = av; in_valid = vv; scan_div = d;
    e.y = ey; e.v = ev; e.e = ee; e.idx = ei;
    sb.push_back(e);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset_n = 1'b0; mode = 1'b0; a = '0; in_valid = 1'b0; scan_div = '0;
    repeat (2) @(posedge clk);
    #1;
    e = '0; sb.push_back(e);
    pop_check("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Direct decode, including zero and out-of-range codes back to back.
    cyc("dec_a5",   1'b0, 4'd5,  1'b1, 16'd2, 1'b1, 12'h010, 1'b1, 1'b0, 4'd0);
    cyc("dec_a12",  1'b0, 4'd12, 1'b1, 16'd2, 1'b1, 12'h800, 1'b1, 1'b0, 4'd0);
    cyc("dec_a0",   1'b0, 4'd0,  1'b1, 16'd2, 1'b1, 12'h000, 1'b1, 1'b0, 4'd0);
    cyc("dec_a14",  1'b0, 4'd14, 1'b1, 16'd2, 1'b1, 12'h000, 1'b1, 1'b1, 4'd0);
    cyc("dec_hold", 1'b0, 4'd7,  1'b0, 16'd2, 1'b1, 12'h000, 1'b1, 1'b0, 4'd0);
    cyc("dec_a1",   1'b0, 4'd1,  1'b1, 16'd2, 1'b1, 12'h001, 1'b1, 1'b0, 4'd0);

    // Scan with scan_div=2: each position held for 3 cycles, full wrap, stop at bit 6.
    for (int c = 0; c <= 54; c++) begin
      cyc($sformatf("scan_c%0d", c), 1'b1, 4'd0, 1'b0, 16'd2, 1'b0,
          12'(12'd1 << ((c / 3) % 12)), 1'b1, 1'b0, 4'(((c / 3) % 12) + 1));
    end

    cyc("leave",      1'b0, 4'd0, 1'b0, 16'd2, 1'b0, 12'h000, 1'b0, 1'b0, 4'd0);
    cyc("idle_dir",   1'b0, 4'd0, 1'b0, 16'd2, 1'b1, 12'h000, 1'b0, 1'b0, 4'd0);
    cyc("mode_wins",  1'b1, 4'd3, 1'b1, 16'd2, 1'b0, 12'h001, 1'b1, 1'b0, 4'd1);
    cyc("leave2",     1'b0, 4'd3, 1'b1, 16'd2, 1'b0, 12'h000, 1'b0, 1'b0, 4'd0);
    cyc("held_a3",    1'b0, 4'd3, 1'b1, 16'd2, 1'b1, 12'h004, 1'b1, 1'b0, 4'd0);

    // scan_div=0 advances every edge; divisor changes take effect at once.
    cyc("d0_enter",   1'b1, 4'd0, 1'b0, 16'd0, 1'b0, 12'h001, 1'b1, 1'b0, 4'd1);
    cyc("d0_s2",      1'b1, 4'd0, 1'b0, 16'd0, 1'b0, 12'h002, 1'b1, 1'b0, 4'd2);
    cyc("d0_s3",      1'b1, 4'd0, 1'b0, 16'd0, 1'b0, 12'h004, 1'b1, 1'b0, 4'd3);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("d3_hold%0d", k), 1'b1, 4'd0, 1'b0, 16'd3, 1'b0, 12'h004, 1'b1, 1'b0, 4'd3);
    cyc("d3_step",    1'b1, 4'd0, 1'b0, 16'd3, 1'b0, 12'h008, 1'b1, 1'b0, 4'd4);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("d5_hold%0d", k), 1'b1, 4'd0, 1'b0, 16'd5, 1'b0, 12'h008, 1'b1, 1'b0, 4'd4);
    cyc("shrink_wrap", 1'b1, 4'd0, 1'b0, 16'd1, 1'b0, 12'h010, 1'b1, 1'b0, 4'd5);
    cyc("d1_hold",     1'b1, 4'd0, 1'b0, 16'd1, 1'b0, 12'h010, 1'b1, 1'b0, 4'd5);
    cyc("d1_step",     1'b1, 4'd0, 1'b0, 16'd1, 1'b0, 12'h020, 1'b1, 1'b0, 4'd6);

    // Asynchronous reset between edges must clear outputs without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    e = '0; sb.push_back(e);
    pop_check("async_rst");
    @(negedge clk);
    mode = 1'b0;
    reset_n = 1'b1;
    cyc("post_rst_a1", 1'b0, 4'd1, 1'b1, 16'd0, 1'b1, 12'h001, 1'b1, 1'b0, 4'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
